// File: rtl/icache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_ctrl_pkg;

    // Controller states: lookup, request issued, waiting on memory, line write.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    localparam int WORD_W  = 16;
    localparam int LINE_W  = 64;
    localparam int ADDR_W  = 16;
    localparam int LADDR_W = 14;

    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0000;

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the instruction cache.
// Reads are asynchronous; writes and the valid clear take effect on the clock edge.
module icache_array
    import icache_ctrl_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = LADDR_W - IW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_valid,
    output logic [TW-1:0]     rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [TW-1:0]     wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic              clr_all
);

    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    // Valid bits: a global clear beats a same-edge line write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data are not reset; they are only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache on the fetch path. Hits return the word in the
// same cycle; misses stall fetch and pull one 64-bit line from backing memory.
//
// Memory handshake: mem_re rises in REQ and stays high, with mem_addr unchanged,
// until a cycle where mem_rdy is high while mem_re is high; that cycle transfers
// mem_rdata and completes the request. mem_rdy seen while mem_re is low is ignored,
// and at most one request is ever outstanding.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int                LINES     = 32,
    parameter int                WPL       = 4,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       if_addr,
    input  logic              if_rd_en,
    input  logic              inval,
    output logic [15:0]       instr,
    output logic              instr_vld,
    output logic              stall,
    output logic [13:0]       mem_addr,
    output logic              mem_re,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output state_t            dbg_state
);

    localparam int IW = $clog2(LINES);
    localparam int OW = $clog2(WPL);
    localparam int TW = ADDR_W - IW - OW;

    state_t            state;
    state_t            state_nxt;
    logic [OW-1:0]     offset;
    logic [IW-1:0]     index;
    logic [TW-1:0]     tag;
    logic              rd_valid;
    logic [TW-1:0]     rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic [WORD_W-1:0] words [WPL];
    logic              hit;
    logic              miss;
    logic              wr_en;
    logic              clr_all;
    logic              inval_pend;
    logic [LINE_W-1:0] line_buf;
    logic              in_mem;

    assign offset = if_addr[OW-1:0];
    assign index  = if_addr[IW+OW-1:OW];
    assign tag    = if_addr[ADDR_W-1:IW+OW];

    assign in_mem = (state == ST_REQ) || (state == ST_WAIT);
    assign hit    = if_rd_en && rd_valid && (rd_tag == tag) && (state == ST_IDLE);
    assign miss   = if_rd_en && !hit && (state == ST_IDLE);

    assign dbg_state = state;

    icache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (mem_addr[IW-1:0]),
        .wr_tag   (mem_addr[LADDR_W-1:IW]),
        .wr_line  (line_buf),
        .clr_all  (clr_all)
    );

    // Split the stored line into its words for the offset mux.
    always_comb begin
        for (int w = 0; w < WPL; w++) begin
            words[w] = rd_line[w*WORD_W +: WORD_W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a miss starts a fill, memory ready moves to the line write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:          if (miss) state_nxt = ST_REQ;
            ST_REQ, ST_WAIT:  state_nxt = mem_rdy ? ST_FILL : ST_WAIT;
            ST_FILL:          state_nxt = ST_IDLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: fetch response, memory request, and array write/clear strobes.
    always_comb begin
        instr     = NOP_INSTR;
        instr_vld = 1'b0;
        stall     = 1'b0;
        mem_re    = 1'b0;
        wr_en     = 1'b0;
        clr_all   = 1'b0;
        case (state)
            ST_IDLE: begin
                stall     = miss;
                instr_vld = hit;
                if (hit) instr = words[offset];
                clr_all   = inval;
            end
            ST_REQ, ST_WAIT: begin
                stall  = 1'b1;
                mem_re = 1'b1;
            end
            ST_FILL: begin
                stall   = 1'b1;
                wr_en   = 1'b1;
                // An invalidate seen during the fill also wipes the line just written.
                clr_all = inval || inval_pend;
            end
            default: ;
        endcase
    end

    // Miss address latch and invalidate deferred until the fill completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            inval_pend <= 1'b0;
        end else begin
            if (miss) mem_addr <= if_addr[ADDR_W-1:OW];
            if (in_mem) begin
                inval_pend <= inval_pend || inval;
            end else if (state == ST_FILL) begin
                inval_pend <= 1'b0;
            end
        end
    end

    // Capture the returned line on the handshake cycle.
    always_ff @(posedge clk) begin
        if (in_mem && mem_rdy) line_buf <= mem_rdata;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized scoreboard bench for icache_ctrl with a behavioural cache model.
module tb_icache_ctrl;
    import icache_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_addr;
    logic        if_rd_en;
    logic        inval;
    logic [15:0] instr;
    logic        instr_vld;
    logic        stall;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Reference cache: which line address each index currently holds.
    bit          mvalid [32];
    logic [13:0] mline  [32];

    int          mem_lat   = 0;
    bit          resp_en   = 1'b0;
    logic [13:0] exp_maddr = '0;

    // Clock and reset.
    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_rd_en  (if_rd_en),
        .inval     (inval),
        .instr     (instr),
        .instr_vld (instr_vld),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .dbg_state (dbg_state)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'hC3A5;
    endfunction

    function automatic logic [63:0] mem_line(input logic [13:0] la);
        logic [63:0] l;
        for (int w = 0; w < 4; w++) l[w*16 +: 16] = mem_word({la, 2'(w)});
        return l;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return mvalid[a[6:2]] && (mline[a[6:2]] == a[15:2]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [15:0] a);
        mvalid[a[6:2]] = 1'b1;
        mline[a[6:2]]  = a[15:2];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Driver: one fetch held until served; inv_at picks the stall cycle carrying inval.
    task automatic fetch(input logic [15:0] a, input int lat, input int inv_at);
        bit h;
        int k;
        int exp_st;
        h = model_hit(a);
        exp_q.push_back(mem_word(a));
        mem_lat   = lat;
        exp_maddr = a[15:2];
        if_addr   = a;
        if_rd_en  = 1'b1;
        inval     = (inv_at == 0);
        k = 0;
        forever begin
            @(negedge clk);
            if (!stall) begin
                inval = (k == 0) && (inv_at == 0);
                break;
            end
            if (k >= 200) break;
            inval = (inv_at == k);
            k++;
        end
        chk("vld_at_release", instr_vld, 1);
        if (h) exp_st = 0;
        else if (inv_at >= 1 && inv_at <= 2 + lat) exp_st = 2 * (3 + lat);
        else exp_st = 3 + lat;
        chk("stall_cycles", k, exp_st);
        if (!h) begin
            if (inv_at >= 0) model_clear();
            model_fill(a);
        end else if (inv_at == 0) begin
            model_clear();
        end
        @(posedge clk); #1;
        inval = 1'b0;
    endtask

    task automatic idle_cycle();
        if_rd_en = 1'b0;
        if_addr  = 16'($urandom);
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_vld", instr_vld, 0);
        @(posedge clk); #1;
    endtask

    // Backing memory: answers mem_re after mem_lat extra cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (resp_en) begin
                mem_rdy = 1'b0;
                if (mem_re) begin
                    chk("mem_addr", mem_addr, exp_maddr);
                    if (cnt == mem_lat) begin
                        mem_rdy   = 1'b1;
                        mem_rdata = mem_line(exp_maddr);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: every served instruction is popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_vld) begin
                if (exp_q.size() == 0) chk("unexpected_vld", instr_vld, 0);
                else chk("instr", instr, exp_q.pop_front());
                chk("vld_without_stall", stall, 0);
            end else begin
                chk("nop_when_invalid", instr, NOP_INSTR_DEF);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_addr = '0; if_rd_en = 1'b0; inval = 1'b0;
        mem_rdy = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_vld", instr_vld, 0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 14'h0000);
        chk("rst_state", dbg_state, ST_IDLE);
        @(posedge clk); #1;

        // Cold miss, then the rest of the line hits back to back.
        fetch(16'h0005, 2, -1);
        for (int i = 4; i < 8; i++) fetch(16'(i), $urandom_range(0, 3), -1);
        idle_cycle();

        // Conflict on index 4.
        fetch(16'h0010, 1, -1);
        fetch(16'h0090, 0, -1);
        fetch(16'h0010, 3, -1);

        // Invalidate while waiting on memory, then invalidate alongside a hit.
        fetch(16'h0020, 3, 2);
        fetch(16'h0020, 0, 0);
        fetch(16'h0021, 1, -1);

        // Minimum-latency fill.
        fetch(16'h0123, 0, -1);
        idle_cycle();

        // Reset in the middle of a fill, then a stray mem_rdy.
        resp_en = 1'b0; mem_rdy = 1'b0;
        if_addr = 16'h0444; if_rd_en = 1'b1;
        @(negedge clk); chk("rstfill_stall", stall, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); chk("rstfill_mem_re", mem_re, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if_rd_en = 1'b0;
        @(negedge clk);
        chk("rstfill_re_drop", mem_re, 0);
        chk("rstfill_stall_drop", stall, 0);
        mem_rdy = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(negedge clk);
        chk("late_rdy_re", mem_re, 0);
        chk("late_rdy_stall", stall, 0);
        chk("late_rdy_state", dbg_state, ST_IDLE);
        model_clear();
        resp_en = 1'b1;
        @(posedge clk); #1;
        fetch(16'h0444, 1, -1);
        fetch(16'h0005, 0, -1);
        fetch(16'hFFFF, 2, -1);
        fetch(16'hFFFC, 0, -1);

        // Random traffic over a small address pool so hits and evictions mix.
        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            int lat;
            int inv;
            if ($urandom_range(0, 15) == 0) a = 16'hFF80 | 16'($urandom_range(0, 31));
            else a = 16'(($urandom_range(0, 2) << 7) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            lat = $urandom_range(0, 4);
            inv = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 2 + lat) : -1;
            fetch(a, lat, inv);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        if_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
